// File: rtl/cdr_tx_pkg.sv
// cdr_tx_pkg: shared types and constants for the CDR pattern transmitter
package cdr_tx_pkg;
  typedef enum logic [1:0] {
    M_PRBS = 2'b00,
    M_ALT  = 2'b01,
    M_BYTE = 2'b10,
    M_ZERO = 2'b11
  } mode_t;
  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA
  } state_t;
  localparam logic [6:0] PRBS_SEED = 7'h7F;
  localparam logic [6:0] PRBS_TAPS = 7'b110_0000;
  localparam int PREAMBLE_BITS = 16;
  localparam logic [7:0] FILLER_BYTE = 8'hAA;
endpackage

// File: rtl/prbs7_gen.sv
// prbs7_gen: x^7+x^6+1 Fibonacci LFSR, output bit is state[6], reload returns to the seed
module prbs7_gen
  import cdr_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       reload,
  output logic [6:0] state
);
  always_ff @(posedge clk) begin
    if (rst || reload) state <= PRBS_SEED;
    else if (step) state <= {state[5:0], ^(state & PRBS_TAPS)};
  end
endmodule

// File: rtl/cdr_pattern_tx.sv
// cdr_pattern_tx: preamble + PRBS7/1010/byte/zero NRZ serializer; define CDR_TX_ERRINJ_EN to build single-bit error injection
module cdr_pattern_tx
  import cdr_tx_pkg::*;
#(
  parameter int UI_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [UI_W-1:0] ui_div,
  input  logic [1:0]      mode,
  input  logic [7:0]      tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  input  logic            err_inj,
  output logic            ser_out,
  output logic            bit_strobe,
  output logic            underrun
);
  state_t state, state_n;
  mode_t mode_q, dmode;
  logic [UI_W-1:0] timer, div_q;
  logic [3:0] bcnt, bcnt_n;
  logic [7:0] hold, shift, src;
  logic [6:0] lfsr;
  logic hold_full, active, start, wrap, emit, last_pre, enter_data, data_bit, load, accept, dbit, inv;
  logic unused_bits;
  assign unused_bits = ^lfsr[5:0];
  assign tx_ready = !hold_full;
  prbs7_gen u_prbs (
    .clk   (clk),
    .rst   (rst),
    .step  (data_bit && dmode == M_PRBS),
    .reload(start),
    .state (lfsr)
  );
  always_comb begin
    active = state != IDLE;
    start = en && !active;
    wrap = en && active && timer == div_q;
    emit = start || wrap;
    last_pre = state == PREAMBLE && bcnt == 4'(PREAMBLE_BITS - 1);
    enter_data = wrap && last_pre;
    data_bit = wrap && (last_pre || state == DATA);
    dmode = enter_data ? mode_t'(mode) : mode_q;
    bcnt_n = (start || enter_data) ? 4'd0 : state == DATA ? {1'b0, bcnt[2:0] + 3'd1} : bcnt + 4'd1;
    load = data_bit && dmode == M_BYTE && bcnt_n[2:0] == 3'd0;
    accept = en && tx_valid && !hold_full;
    src = hold_full ? hold : FILLER_BYTE;
    dbit = dmode == M_PRBS ? lfsr[6] : dmode == M_ALT ? !bcnt_n[0] : dmode == M_BYTE ? (load ? src[7] : shift[6]) : 1'b0;
    state_n = !en ? IDLE : !active ? PREAMBLE : enter_data ? DATA : state;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
      div_q <= '0;
      bcnt <= '0;
      mode_q <= M_PRBS;
      shift <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      ser_out <= 1'b0;
      bit_strobe <= 1'b0;
      underrun <= 1'b0;
    end else begin
      timer <= (emit || !en || !active) ? '0 : timer + UI_W'(1);
      if (emit) div_q <= ui_div;
      if (emit) bcnt <= bcnt_n;
      if (enter_data) mode_q <= mode_t'(mode);
      if (load) shift <= src;
      else if (data_bit && dmode == M_BYTE) shift <= {shift[6:0], 1'b0};
      if (accept) hold <= tx_data;
      hold_full <= accept || (hold_full && !load);
      ser_out <= emit ? (data_bit ? dbit : !bcnt_n[0]) ^ inv : en && active && ser_out;
      bit_strobe <= emit;
      underrun <= underrun || (load && !hold_full);
    end
  end
`ifdef CDR_TX_ERRINJ_EN
  logic err_q;
  always_ff @(posedge clk) begin
    err_q <= (rst || !en || !active || wrap) ? 1'b0 : err_q || err_inj;
  end
  assign inv = wrap && (err_q || err_inj);
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign inv = 1'b0;
`endif
endmodule

// File: doc/cdr_pattern_tx.md
CDR_PATTERN_TX -- requirements
Module: cdr_pattern_tx

Interface
REQ-001 Parameter: UI_W, default 8, width of the bit-period divider.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  transmitter enable.
REQ-005 ui_div  input  UI_W  clock cycles per bit minus 1.
REQ-006 mode  input  2  pattern select: 00 PRBS7, 01 alternating 1010, 10 byte stream, 11 constant 0.
REQ-007 tx_data  input  8  byte to transmit in mode 10.
REQ-008 tx_valid  input  1  tx_data valid.
REQ-009 tx_ready  output  1  holding register empty.
REQ-010 err_inj  input  1  single-bit error injection request (pulse).
REQ-011 ser_out  output  1  registered NRZ serial data.
REQ-012 bit_strobe  output  1  registered, high on the first cycle of each bit.
REQ-013 underrun  output  1  sticky, set when byte mode starves.

Function
REQ-014 FSM states are IDLE, PREAMBLE and DATA; en low in any state forces IDLE on the next cycle, aborting the current bit.
REQ-015 IDLE -> PREAMBLE on the first cycle with en=1: the next cycle has bit_strobe=1 and ser_out=1.
REQ-016 PREAMBLE sends 16 bits of 1,0,1,0..., then enters DATA at the next bit boundary.
REQ-017 mode is sampled only on the PREAMBLE->DATA transition; changes take effect only after en is toggled.
REQ-018 Bit timer counts 0..ui_div; a bit boundary occurs when the count wraps, and bit_strobe marks the cycle after the wrap.
REQ-019 ui_div is sampled at each bit boundary; ui_div=0 gives one bit per cycle with bit_strobe held high.
REQ-020 PRBS7 uses x^7+x^6+1, seed 7'h7F, reloaded on entry to PREAMBLE; it steps once per DATA bit and drives ser_out from lfsr[6].
REQ-021 In byte mode, a one-byte holding register feeds an 8-bit shift register; bits go out MSB first.
REQ-022 tx_ready = !hold_full; a transfer occurs on tx_valid&&tx_ready; an accept and a drain in the same cycle leave hold_full=1.
REQ-023 The shift register loads from the holding register at each byte boundary; if the holding register is empty, it loads the filler 8'hAA and sets underrun.
REQ-024 underrun clears only on rst.
REQ-025 Byte acceptance is allowed in any state while en=1; the holding contents survive en deassertion.
REQ-026 An err_inj pulse is latched and inverts ser_out for exactly the next full bit; multiple pulses before that bit merge into one.
REQ-027 Error injection never alters the LFSR, shift register or preamble sequence.
REQ-028 In IDLE: ser_out=0 and bit_strobe=0.

Reset
REQ-029 On rst=1 at a clock edge:
- state=IDLE, timer=0, lfsr=7'h7F, shift=0
- hold_full=0, err latch=0
- ser_out=0, bit_strobe=0, tx_ready=1, underrun=0
REQ-030 rst asserted mid-bit or mid-byte discards all in-flight data, including the holding register.

Configuration
REQ-031 Macro CDR_TX_ERRINJ_EN controls error injection:
- Defined: REQ-026 and REQ-027 apply.
- Undefined: err_inj is ignored, no latch is built, and the port remains present.

Structure
REQ-032 Package cdr_tx_pkg holds:
- mode enum and FSM state enum
- PRBS7 seed and taps
- PREAMBLE_BITS=16
- FILLER_BYTE=8'hAA
REQ-033 PRBS7 is a separate sub-module prbs7_gen, with step and reload inputs and a 7-bit state output.

Verification
REQ-034 Check preamble and PRBS: ui_div=3, mode=00, en rises → first bit_strobe one cycle later, 16 preamble bits of 4 cycles each, then PRBS7 with period 127 bits and first bits 1,1,1,1,1,1,1,0.
REQ-035 Check byte stream: ui_div=0, mode=10, bytes 8'h3C then 8'hF0 preloaded → after the preamble, ser_out sequence 00111100 11110000, then filler 10101010 with underrun=1.
REQ-036 Check the holding register: tx_valid held high continuously → tx_ready deasserts while the holding register is full and reasserts exactly one cycle after each byte boundary load.
REQ-037 Check error injection (macro defined): err_inj pulse during PRBS bit n → bit n+1 inverted, bit n+2 onward matches the golden PRBS.
REQ-038 Check abort: en or rst dropped mid-byte at ui_div=5 → next cycle ser_out=0, bit_strobe=0, IDLE; after rst, tx_ready=1 and underrun=0.
REQ-039 Check the divider change: ui_div changed 2→7 mid-bit → the current bit keeps 3 cycles and the next bit lasts 8 cycles.
